// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one SRAM-like memory bus between the CPU instruction-fetch port and
// the MEM-stage data port. Only one bus transaction is outstanding at a time.
// Data requests win by default. A starvation counter lets fetch win once after
// STARVE_MAX consecutive data grants that were made while fetch was waiting.
//
// Ports
//   clk, resetn                     clock, asynchronous active-low reset
//   inst_req/inst_addr              fetch request (always a word read)
//   inst_addr_ok/inst_data_ok       fetch accept / fetch read data valid
//   inst_rdata                      fetch read data (bus_rdata passthrough)
//   data_req/wr/size/addr/wdata     MEM-stage request fields
//   data_addr_ok/data_data_ok       data accept / read data valid or write done
//   data_rdata                      data read data (bus_rdata passthrough)
//   bus_req/wr/size/addr/wdata      registered request toward the bus bridge
//   bus_addr_ok/bus_data_ok         bridge request accept / response
//   bus_rdata                       bridge read data
//   busy                            a transaction is in progress
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             owner;        // 0 = inst, 1 = data
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             grant_inst;
    logic             grant_data;

    // Fetch has waited through STARVE_MAX data grants: it wins this time.
    assign starve_hit = inst_req && (starve_cnt == CNT_MAX);

    always_comb begin
        next_state   = state;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            IDLE: begin
                // Gated with resetn so no accept pulse escapes while in reset.
                if (resetn) begin
                    if (data_req && !starve_hit) begin
                        grant_data = 1'b1;
                    end else if (inst_req) begin
                        grant_inst = 1'b1;
                    end
                end
                if (grant_data || grant_inst) begin
                    next_state = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    inst_data_ok = !owner;
                    data_data_ok = owner;
                    next_state   = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_size   <= 2'b00;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            state <= next_state;
            if (grant_data) begin
                owner     <= 1'b1;
                bus_req   <= 1'b1;
                bus_wr    <= data_wr;
                bus_size  <= data_size;
                bus_addr  <= data_addr;
                bus_wdata <= data_wdata;
                // Only count data grants that actually made fetch wait.
                if (!inst_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_inst) begin
                owner      <= 1'b0;
                bus_req    <= 1'b1;
                bus_wr     <= 1'b0;
                bus_size   <= 2'b10;
                bus_addr   <= inst_addr;
                bus_wdata  <= '0;
                starve_cnt <= '0;
            end else if (state == ADDR && bus_addr_ok) begin
                bus_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter. Inputs change 1 time unit after each
// rising edge; outputs are sampled 2 units later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    int checks_total;
    int checks_passed;

    mem_bus_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in a grant cycle; bus accepts at once and responds the cycle
    // after. Returns in the IDLE cycle following the response.
    task automatic serve(input logic exp_owner);
        tick();
        bus_addr_ok = 1'b1;
        #2;
        chk("serve_no_addr_ok_in_addr", {inst_addr_ok, data_addr_ok}, 2'b00);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        #2;
        chk("serve_inst_data_ok", inst_data_ok, !exp_owner);
        chk("serve_data_data_ok", data_data_ok, exp_owner);
        tick();
        bus_data_ok = 1'b0;
    endtask

    logic [5:0] starve_order;
    logic [2:0] starve_exp [6];

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        resetn      = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h0;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;

        // ---------------- reset state ----------------
        tick();
        tick();
        #2;
        chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk("rst_data_addr_ok", data_addr_ok, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_bus_fields", {bus_wr, bus_size, bus_addr, bus_wdata}, 67'h0);
        tick();
        inst_req = 1'b0;
        data_req = 1'b0;
        resetn   = 1'b1;

        // ---------------- 1: single fetch ----------------
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #2;
        chk("t1_inst_addr_ok_c0", inst_addr_ok, 1'b1);
        chk("t1_bus_req_c0", bus_req, 1'b0);
        tick();
        inst_req  = 1'b0;
        inst_addr = 32'h0;
        #2;
        chk("t1_bus_req_c1", bus_req, 1'b1);
        chk("t1_bus_addr", bus_addr, 32'hBFC0_0000);
        chk("t1_bus_wr_size", {bus_wr, bus_size}, 3'b010);
        chk("t1_bus_wdata", bus_wdata, 32'h0);
        chk("t1_busy", busy, 1'b1);
        tick();
        bus_addr_ok = 1'b1;
        #2;
        chk("t1_bus_req_c2", bus_req, 1'b1);
        tick();
        bus_addr_ok = 1'b0;
        #2;
        chk("t1_bus_req_c3", bus_req, 1'b0);
        chk("t1_no_data_ok_c3", inst_data_ok, 1'b0);
        tick();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h3C08_0001;
        #2;
        chk("t1_inst_data_ok_c4", inst_data_ok, 1'b1);
        chk("t1_inst_rdata", inst_rdata, 32'h3C08_0001);
        chk("t1_data_data_ok_c4", data_data_ok, 1'b0);
        tick();
        bus_data_ok = 1'b0;
        #2;
        chk("t1_idle_c5", {busy, inst_data_ok}, 2'b00);

        // ---------------- 2: simultaneous requests ----------------
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h1000_0000;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h8000_0040;
        #2;
        chk("t2_data_addr_ok", data_addr_ok, 1'b1);
        chk("t2_inst_addr_ok", inst_addr_ok, 1'b0);
        tick();
        data_req = 1'b0;
        #2;
        chk("t2_bus_addr", bus_addr, 32'h8000_0040);
        chk("t2_inst_wait", inst_addr_ok, 1'b0);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        #2;
        chk("t2_data_data_ok", data_data_ok, 1'b1);
        chk("t2_inst_data_ok", inst_data_ok, 1'b0);
        chk("t2_inst_not_yet", inst_addr_ok, 1'b0);
        tick();
        bus_data_ok = 1'b0;
        #2;
        chk("t2_inst_addr_ok_next", inst_addr_ok, 1'b1);
        chk("t2_starve_cnt", dut.starve_cnt, 3'd1);
        serve(1'b0);
        inst_req = 1'b0;
        #2;
        chk("t2_starve_cleared", dut.starve_cnt, 3'd0);

        // ---------------- 3: starvation ----------------
        // Bit k = 1 means grant k goes to data: D,D,D,D,I,D
        starve_order = 6'b101111;
        starve_exp[0] = 3'd0;
        starve_exp[1] = 3'd1;
        starve_exp[2] = 3'd2;
        starve_exp[3] = 3'd3;
        starve_exp[4] = 3'd4;
        starve_exp[5] = 3'd0;
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0100;
        data_req  = 1'b1;
        data_addr = 32'h8000_0080;
        for (int k = 0; k < 6; k++) begin
            #2;
            chk("t3_starve_cnt", dut.starve_cnt, starve_exp[k]);
            chk("t3_data_grant", data_addr_ok, starve_order[k]);
            chk("t3_inst_grant", inst_addr_ok, !starve_order[k]);
            serve(starve_order[k]);
        end
        inst_req = 1'b0;
        data_req = 1'b0;

        // ---------------- 4: store byte ----------------
        tick();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd0;
        data_addr  = 32'h8000_1003;
        data_wdata = 32'h0000_00AB;
        #2;
        chk("t4_data_addr_ok", data_addr_ok, 1'b1);
        tick();
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = 32'h0;
        data_wdata = 32'hFFFF_FFFF;
        #2;
        chk("t4_bus_fields_c1", {bus_req, bus_wr, bus_size, bus_addr, bus_wdata},
            {1'b1, 1'b1, 2'd0, 32'h8000_1003, 32'h0000_00AB});
        tick();
        bus_addr_ok = 1'b1;
        #2;
        chk("t4_bus_fields_c2", {bus_req, bus_wr, bus_size, bus_addr, bus_wdata},
            {1'b1, 1'b1, 2'd0, 32'h8000_1003, 32'h0000_00AB});
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        #2;
        chk("t4_bus_req_dropped", bus_req, 1'b0);
        chk("t4_data_data_ok", data_data_ok, 1'b1);
        tick();
        bus_data_ok = 1'b0;

        // ---------------- 5: stray and late responses ----------------
        bus_data_ok = 1'b1;
        bus_addr_ok = 1'b1;
        #2;
        chk("t5_stray_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        tick();
        bus_data_ok = 1'b0;
        bus_addr_ok = 1'b0;
        #2;
        chk("t5_stray_no_state", {busy, bus_req}, 2'b00);
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0200;
        #2;
        chk("t5_grant", inst_addr_ok, 1'b1);
        tick();
        inst_req    = 1'b0;
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        #2;
        chk("t5_in_data", {busy, bus_req}, 2'b10);
        tick();
        bus_addr_ok = 1'b1;
        resetn = 1'b0;
        #2;
        chk("t5_async_reset", {busy, bus_req}, 2'b00);
        tick();
        bus_addr_ok = 1'b0;
        resetn      = 1'b1;
        bus_data_ok = 1'b1;
        #2;
        chk("t5_late_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        tick();
        bus_data_ok = 1'b0;
        #2;
        chk("t5_after_late", {busy, bus_req}, 2'b00);

        // ---------------- 6: back-pressure ----------------
        tick();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_addr  = 32'h0000_1234;
        data_wdata = 32'h0000_CAFE;
        inst_req   = 1'b1;
        #2;
        chk("t6_grant", data_addr_ok, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            #2;
            chk("t6_bus_held", {bus_req, bus_wr, bus_size, bus_addr, bus_wdata},
                {1'b1, 1'b1, 2'd1, 32'h0000_1234, 32'h0000_CAFE});
            chk("t6_no_second_grant", {inst_addr_ok, data_addr_ok}, 2'b00);
        end
        data_req    = 1'b0;
        inst_req    = 1'b0;
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        #2;
        chk("t6_data_data_ok", data_data_ok, 1'b1);
        tick();
        bus_data_ok = 1'b0;
        #2;
        chk("t6_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
